// File: rtl/serial_msg_receiver.sv
`default_nettype none
// ============================================================================
// Module   : serial_msg_receiver
// Purpose  : Receives 8-period serial frames (start, d0..d4, parity, stop)
//            on an asynchronous line and reports the 5-bit data word with
//            parity and framing status pulses.
// Ports    : clk        - system clock, rising-edge active
//            rst        - synchronous, active-high reset
//            din        - serial line, idle level 1 (asynchronous)
//            div[9:0]   - bit period in clk cycles; effective max(div, 2)
//            mode       - parity select: 0 = even, 1 = odd
//            msg_out    - last correctly framed data word (d0 = LSB)
//            valid      - one-cycle pulse: frame received with stop bit 1
//            err_parity - one-cycle pulse alongside valid on parity error
//            err_frame  - one-cycle pulse when the stop bit samples 0
//            busy       - high whenever the receiver is not idle
// Revision : 1.0 - initial release
// ============================================================================
module serial_msg_receiver (
    input  logic       clk,
    input  logic       rst,
    input  logic       din,
    input  logic [9:0] div,
    input  logic       mode,
    output logic [4:0] msg_out,
    output logic       valid,
    output logic       err_parity,
    output logic       err_frame,
    output logic       busy
);

    localparam logic [9:0] c_MIN_PERIOD = 10'd2;
    localparam logic [2:0] c_LAST_BIT   = 3'd4;

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_START  = 3'd1,
        S_DATA   = 3'd2,
        S_PARITY = 3'd3,
        S_STOP   = 3'd4
    } state_t;

    state_t     state_q, state_d;
    logic [9:0] cnt_q, cnt_d;
    logic [2:0] bit_idx_q, bit_idx_d;
    logic [4:0] data_q, data_d;
    logic       parity_q, parity_d;
    logic [4:0] msg_q, msg_d;
    logic       valid_q, valid_d;
    logic       err_parity_q, err_parity_d;
    logic       err_frame_q, err_frame_d;
    logic       din_meta_q;
    logic       din_s_q;

    logic [9:0] w_period;
    logic [9:0] w_half_m1;
    logic [9:0] w_full_m1;

    assign w_period  = (div < c_MIN_PERIOD) ? c_MIN_PERIOD : div;
    assign w_half_m1 = (w_period >> 1) - 10'd1;
    assign w_full_m1 = w_period - 10'd1;

    // Terminal counts use >= so that a period shortened mid-frame still
    // ends the current bit instead of letting cnt run past P-1 and wrap.
    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        bit_idx_d    = bit_idx_q;
        data_d       = data_q;
        parity_d     = parity_q;
        msg_d        = msg_q;
        valid_d      = 1'b0;
        err_parity_d = 1'b0;
        err_frame_d  = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (!din_s_q) begin
                    state_d = S_START;
                    cnt_d   = 10'd0;
                end
            end

            S_START: begin
                if (cnt_q >= w_half_m1) begin
                    cnt_d = 10'd0;
                    if (!din_s_q) begin
                        state_d   = S_DATA;
                        bit_idx_d = 3'd0;
                    end else begin
                        // Glitch shorter than half a bit: silently drop it.
                        state_d = S_IDLE;
                    end
                end else begin
                    cnt_d = cnt_q + 10'd1;
                end
            end

            S_DATA: begin
                if (cnt_q >= w_full_m1) begin
                    cnt_d             = 10'd0;
                    data_d[bit_idx_q] = din_s_q;
                    if (bit_idx_q == c_LAST_BIT) begin
                        state_d = S_PARITY;
                    end else begin
                        bit_idx_d = bit_idx_q + 3'd1;
                    end
                end else begin
                    cnt_d = cnt_q + 10'd1;
                end
            end

            S_PARITY: begin
                if (cnt_q >= w_full_m1) begin
                    cnt_d    = 10'd0;
                    parity_d = din_s_q;
                    state_d  = S_STOP;
                end else begin
                    cnt_d = cnt_q + 10'd1;
                end
            end

            S_STOP: begin
                if (cnt_q >= w_full_m1) begin
                    cnt_d   = 10'd0;
                    state_d = S_IDLE;
                    if (din_s_q) begin
                        msg_d        = data_q;
                        valid_d      = 1'b1;
                        // XOR over data+parity must equal the selected sense.
                        err_parity_d = ((^data_q) ^ parity_q) != mode;
                    end else begin
                        err_frame_d  = 1'b1;
                    end
                end else begin
                    cnt_d = cnt_q + 10'd1;
                end
            end

            default: begin
                state_d = S_IDLE;
                cnt_d   = 10'd0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= S_IDLE;
            cnt_q        <= 10'd0;
            bit_idx_q    <= 3'd0;
            data_q       <= 5'd0;
            parity_q     <= 1'b0;
            msg_q        <= 5'd0;
            valid_q      <= 1'b0;
            err_parity_q <= 1'b0;
            err_frame_q  <= 1'b0;
            din_meta_q   <= 1'b1;
            din_s_q      <= 1'b1;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            bit_idx_q    <= bit_idx_d;
            data_q       <= data_d;
            parity_q     <= parity_d;
            msg_q        <= msg_d;
            valid_q      <= valid_d;
            err_parity_q <= err_parity_d;
            err_frame_q  <= err_frame_d;
            din_meta_q   <= din;
            din_s_q      <= din_meta_q;
        end
    end

    assign msg_out    = msg_q;
    assign valid      = valid_q;
    assign err_parity = err_parity_q;
    assign err_frame  = err_frame_q;
    assign busy       = (state_q != S_IDLE);

endmodule
`default_nettype wire
